sram_axi_arbiter: RTL
=====================

# sram_axi_arbiter

Shares one AXI master port between the instruction-fetch SRAM-like port (read-only, ARID 0) and the data SRAM-like port (read/write, ARID/AWID 1). Converts req/addr_ok/data_ok transactions into single-beat AXI transfers and routes R/B responses back by ID. Sits between the pipeline's fetch/memory stages and the top-level AXI interface. Its `arid` output feeds fetch-stage cancel logic.

## Interface
- Parameters: none. All AXI widths are fixed at 32-bit address/data and 4-bit ID.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- inst_sram_req / inst_sram_wr / inst_sram_size[1:0] / inst_sram_addr[31:0] / inst_sram_wstrb[3:0] / inst_sram_wdata[31:0]  in  fetch request; wr/wstrb/wdata ignored
- inst_sram_addr_ok / inst_sram_data_ok  out  1  accept / response strobes
- inst_sram_rdata  out  32  = rdata
- data_sram_req / data_sram_wr / data_sram_size[1:0] / data_sram_addr[31:0] / data_sram_wstrb[3:0] / data_sram_wdata[31:0]  in  data request
- data_sram_addr_ok / data_sram_data_ok  out  1;  data_sram_rdata  out  32
- arid[3:0] araddr[31:0] arlen[7:0] arsize[2:0] arburst[1:0] arlock[1:0] arcache[3:0] arprot[2:0] arvalid  out;  arready  in
- rid[3:0] rdata[31:0] rresp[1:0] rlast rvalid  in;  rready  out
- awid awaddr awlen awsize awburst awlock awcache awprot awvalid  out (same widths as AR);  awready  in
- wid[3:0] wdata[31:0] wstrb[3:0] wlast wvalid  out;  wready  in
- bid[3:0] bresp[1:0] bvalid  in;  bready  out

## Operation
- Constant outputs: arlen = awlen = 0, arburst = awburst = 2'b01, lock/cache/prot = 0, wlast = 1, awid = wid = 1. Set arsize/awsize = {1'b0, size}.
- Per-ID pending flags: rd_pend[0] (inst), rd_pend[1] (data), wr_pend (data). At most one outstanding transaction per flag.
- Read FSM states:
  - AR_IDLE: grant the data read if data_sram_req & ~data_sram_wr & ~rd_pend[1] & ~wr_pend. Otherwise grant the inst read if inst_sram_req & ~rd_pend[0]. On a grant, pulse that port's addr_ok combinationally, latch id/addr/size, set the pending flag, and go to AR_SEND.
  - AR_SEND: hold arvalid = 1 with stable fields. On arready, return to AR_IDLE.
  - No grant occurs while in AR_SEND.
- Write FSM states:
  - W_IDLE: accept when data_sram_req & data_sram_wr & ~rd_pend[1] & ~wr_pend & the read FSM is not granting data this cycle. Pulse data addr_ok, latch addr/size/wstrb/wdata, set wr_pend, and go to W_SEND.
  - W_SEND: raise awvalid and wvalid together. Each drops independently on its own ready. When both are done, go to W_RESP.
  - W_RESP: bready = 1. On bvalid, go to W_IDLE and clear wr_pend.
- R channel: rready is constantly 1.
  - rvalid & rid == 0 → inst_sram_data_ok = 1 and clear rd_pend[0].
  - rvalid & rid == 1 → data_sram_data_ok = 1 and clear rd_pend[1].
- data_sram_data_ok = (rvalid & rid == 1) | (bvalid & bready). Both terms are never true in the same cycle, because a data read and a data write are mutually exclusive.
- rresp and bresp are ignored.

## Timing
- Reset values: all valid outputs 0, bready 0, all addr_ok/data_ok 0, rready 1, arid 0. FSMs return to IDLE and pending flags clear.
- addr_ok is combinational in the request cycle (cycle 0). arvalid/awvalid/wvalid assert from cycle 1.
- data_ok and rdata are combinational from rvalid/bvalid. Minimum read latency is request → data_ok = 2 cycles (AR handshake in cycle 1, R in cycle 2).
- Fields driven with arvalid stay stable until arready. The same holds for awvalid and wvalid with their readies.
- A new grant is possible in the cycle after arready, and the read FSM can have two reads in flight (one per ID). Responses may return in any order.
- A response arriving in the same cycle that a grant sets a different ID's pending flag: both take effect.
- Reset mid-transaction: everything aborts at once with no drain. The AXI slave is assumed to be reset in the same cycle.

## Structure
- Shared package `axi_pkg`:
  - constants ID_INST = 4'd0, ID_DATA = 4'd1, BURST_INCR, LEN_SINGLE
  - typedefs rd_state_t {AR_IDLE, AR_SEND} and wr_state_t {W_IDLE, W_SEND, W_RESP}
- One sub-module, `axi_wr_ctrl`, holds the write FSM, the AW/W/B latches and wr_pend. The top level keeps read arbitration and response routing.

## Test plan
- Single inst read, addr 0x1c000000, arready=1, R after 1 cycle with rid 0, rdata 0xDEADBEEF → addr_ok in cycle 0, arvalid in cycle 1, inst data_ok with 0xDEADBEEF in cycle 2.
- Inst and data reads requested in the same cycle → data granted first (arid 1), inst granted in the cycle after arready (arid 0). Out-of-order R (rid 0 before rid 1) routes to the correct ports.
- Data write, addr 0x100, wdata 0x12345678, wstrb 0xF; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held stable 3 cycles, data_ok on bvalid.
- Data read requested while a write is in W_RESP → no addr_ok until the cycle after bvalid, then granted.
- Second inst req while rd_pend[0] is set → no addr_ok until the rid 0 response, even with arready=1.
- Reset asserted while in AR_SEND and W_SEND → arvalid/awvalid/wvalid drop immediately (asynchronous). After release, all pending flags are 0 and a new inst read is accepted in the first cycle.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared constants and state types for the SRAM-like to AXI bridge.
package axi_pkg;

    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    typedef enum logic {AR_IDLE, AR_SEND} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wr_state_t;

    // SRAM-like size (bytes = 1 << size) maps straight onto AxSIZE.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_wr_ctrl.sv
// Write path: accepts one data-port write, issues AW and W together, waits for B.
module axi_wr_ctrl
    import axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    input  logic        rd_pend_data,
    input  logic        rd_grant_data,
    input  logic        awready,
    input  logic        wready,
    input  logic        bvalid,
    output logic        accept,
    output logic        wr_pend,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    output logic        bready,
    output wr_state_t   state
);

    // Valid/ready: a channel's fields are held stable while its valid is high;
    // the transfer happens on the edge where valid and ready are both high.
    assign accept = (state == W_IDLE) & data_req & data_wr & ~rd_pend_data
                  & ~wr_pend & ~rd_grant_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= W_IDLE;
            wr_pend <= 1'b0;
            awaddr  <= '0;
            awsize  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (accept) begin
                        awaddr  <= data_addr;
                        awsize  <= axi_size(data_size);
                        wdata   <= data_wdata;
                        wstrb   <= data_wstrb;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        wr_pend <= 1'b1;
                        state   <= W_SEND;
                    end
                end
                W_SEND: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    // AW and W may complete in either order or together.
                    if ((~awvalid | awready) & (~wvalid | wready)) begin
                        bready <= 1'b1;
                        state  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        wr_pend <= 1'b0;
                        state   <= W_IDLE;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI master between the fetch (ID 0) and data (ID 1) SRAM-like ports.
module sram_axi_arbiter
    import axi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output rd_state_t   dbg_rd_state,
    output wr_state_t   dbg_wr_state
);

    rd_state_t  rd_state;
    logic [1:0] rd_pend;
    logic       wr_pend, wr_accept, grant_data_rd, grant_inst_rd, r_inst, r_data;
    logic       unused;

    assign unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

    // Data reads win; a data read also waits out any pending data write (and vice versa).
    assign grant_data_rd = (rd_state == AR_IDLE) & data_sram_req & ~data_sram_wr
                         & ~rd_pend[1] & ~wr_pend;
    assign grant_inst_rd = (rd_state == AR_IDLE) & ~grant_data_rd & inst_sram_req & ~rd_pend[0];
    assign r_inst = rvalid & (rid == ID_INST);
    assign r_data = rvalid & (rid == ID_DATA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state <= AR_IDLE;
            rd_pend  <= 2'b00;
            arid     <= ID_INST;
            araddr   <= '0;
            arsize   <= '0;
            arvalid  <= 1'b0;
        end else begin
            case (rd_state)
                AR_IDLE: begin
                    if (grant_data_rd) begin
                        arid     <= ID_DATA;
                        araddr   <= data_sram_addr;
                        arsize   <= axi_size(data_sram_size);
                        arvalid  <= 1'b1;
                        rd_state <= AR_SEND;
                    end else if (grant_inst_rd) begin
                        arid     <= ID_INST;
                        araddr   <= inst_sram_addr;
                        arsize   <= axi_size(inst_sram_size);
                        arvalid  <= 1'b1;
                        rd_state <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rd_state <= AR_IDLE;
                    end
                end
                default: rd_state <= AR_IDLE;
            endcase
            // A grant only targets an idle ID, so set and clear never collide on one bit.
            rd_pend[0] <= grant_inst_rd | (rd_pend[0] & ~r_inst);
            rd_pend[1] <= grant_data_rd | (rd_pend[1] & ~r_data);
        end
    end

    axi_wr_ctrl u_wr (
        .clk          (clk),
        .rst          (reset),
        .data_req     (data_sram_req),
        .data_wr      (data_sram_wr),
        .data_size    (data_sram_size),
        .data_addr    (data_sram_addr),
        .data_wstrb   (data_sram_wstrb),
        .data_wdata   (data_sram_wdata),
        .rd_pend_data (rd_pend[1]),
        .rd_grant_data(grant_data_rd),
        .awready      (awready),
        .wready       (wready),
        .bvalid       (bvalid),
        .accept       (wr_accept),
        .wr_pend      (wr_pend),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .bready       (bready),
        .state        (dbg_wr_state)
    );

    assign inst_sram_addr_ok = grant_inst_rd;
    assign data_sram_addr_ok = grant_data_rd | wr_accept;
    assign inst_sram_data_ok = r_inst;
    assign data_sram_data_ok = r_data | (bvalid & bready);
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arlen   = LEN_SINGLE;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign rready  = 1'b1;
    assign awid    = ID_DATA;
    assign awlen   = LEN_SINGLE;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = ID_DATA;
    assign wlast   = 1'b1;
    assign dbg_rd_state = rd_state;

endmodule
